// File: rtl/vscale_mem_arbiter_if.sv
// Request/response bundle between the fetch and data requesters, the arbiter,
// and the shared backing memory port.
interface vscale_mem_arbiter_if;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_wait;
  logic        imem_badmem_e;

  logic        dmem_en;
  logic        dmem_wen;
  logic [2:0]  dmem_size;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_wait;
  logic        dmem_badmem_e;

  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [2:0]  mem_size;
  logic [31:0] mem_wdata;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;
  logic        mem_resp_err;

  // Arbiter view: serves both requesters and drives the backing port.
  modport slave (
    input  imem_en, imem_addr,
    output imem_rdata, imem_wait, imem_badmem_e,
    input  dmem_en, dmem_wen, dmem_size, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_wait, dmem_badmem_e,
    output mem_req_valid, mem_addr, mem_wen, mem_size, mem_wdata,
    input  mem_req_ready, mem_resp_valid, mem_rdata, mem_resp_err
  );

  // Environment view: requesters plus the memory model.
  modport master (
    output imem_en, imem_addr,
    input  imem_rdata, imem_wait, imem_badmem_e,
    output dmem_en, dmem_wen, dmem_size, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_wait, dmem_badmem_e,
    input  mem_req_valid, mem_addr, mem_wen, mem_size, mem_wdata,
    output mem_req_ready, mem_resp_valid, mem_rdata, mem_resp_err
  );
endinterface

// File: rtl/vscale_mem_arbiter.sv
// Shares one memory port between fetch and data with one transaction in flight;
// data has priority, bounded by a streak limit so fetch cannot starve.
module vscale_mem_arbiter #(
  parameter int unsigned STREAK_MAX = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  vscale_mem_arbiter_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_e;

  localparam logic [3:0] STREAK_LIM = 4'(STREAK_MAX);

  state_e     state_q, state_d;
  logic [3:0] streak_q, streak_d;
  logic       dmem_win, imem_win;
  logic       d_misal, i_misal;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      2'd0:    return 1'b0;
      2'd1:    return addr_lo[0];
      2'd2:    return addr_lo != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] streak_next(input logic dmem_won, input logic imem_req,
                                             input logic [3:0] cur);
    if (dmem_won && imem_req)
      return (cur == STREAK_LIM) ? cur : cur + 4'd1;
    else
      return 4'd0;
  endfunction

  assign dmem_win = bus.dmem_en && !(bus.imem_en && (streak_q == STREAK_LIM));
  assign imem_win = !dmem_win && bus.imem_en;
  assign d_misal  = misaligned(bus.dmem_size[1:0], bus.dmem_addr[1:0]);
  assign i_misal  = misaligned(2'd2, bus.imem_addr[1:0]);

  // Everything is gated by reset so a transaction cut short never completes.
  always_comb begin
    state_d           = state_q;
    streak_d          = streak_q;
    bus.mem_req_valid = 1'b0;
    bus.mem_addr      = '0;
    bus.mem_wen       = 1'b0;
    bus.mem_size      = '0;
    bus.mem_wdata     = '0;
    bus.imem_wait     = bus.imem_en;
    bus.imem_rdata    = '0;
    bus.imem_badmem_e = 1'b0;
    bus.dmem_wait     = bus.dmem_en;
    bus.dmem_rdata    = '0;
    bus.dmem_badmem_e = 1'b0;

    if (!reset) begin
      case (state_q)
        IDLE: begin
          if (dmem_win) begin
            if (d_misal) begin
              bus.dmem_wait     = 1'b0;
              bus.dmem_badmem_e = 1'b1;
              streak_d          = streak_next(1'b1, bus.imem_en, streak_q);
            end else begin
              bus.mem_req_valid = 1'b1;
              bus.mem_addr      = bus.dmem_addr;
              bus.mem_wen       = bus.dmem_wen;
              bus.mem_size      = bus.dmem_size;
              bus.mem_wdata     = bus.dmem_wdata;
              if (bus.mem_req_ready) begin
                state_d  = BUSY_D;
                streak_d = streak_next(1'b1, bus.imem_en, streak_q);
              end
            end
          end else if (imem_win) begin
            if (i_misal) begin
              bus.imem_wait     = 1'b0;
              bus.imem_badmem_e = 1'b1;
              streak_d          = streak_next(1'b0, bus.imem_en, streak_q);
            end else begin
              bus.mem_req_valid = 1'b1;
              bus.mem_addr      = bus.imem_addr;
              bus.mem_size      = 3'b010;
              if (bus.mem_req_ready) begin
                state_d  = BUSY_I;
                streak_d = streak_next(1'b0, bus.imem_en, streak_q);
              end
            end
          end
        end
        BUSY_I: begin
          if (bus.mem_resp_valid) begin
            bus.imem_wait     = 1'b0;
            bus.imem_rdata    = bus.mem_rdata;
            bus.imem_badmem_e = bus.mem_resp_err;
            state_d           = IDLE;
          end
        end
        BUSY_D: begin
          if (bus.mem_resp_valid) begin
            bus.dmem_wait     = 1'b0;
            bus.dmem_rdata    = bus.mem_rdata;
            bus.dmem_badmem_e = bus.mem_resp_err;
            state_d           = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      streak_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
    end
  end

endmodule

// File: tb/tb_vscale_mem_arbiter.sv
// Directed bench for vscale_mem_arbiter: reset, priority/streak order, misalignment,
// back-pressure, error response and reset mid-transaction.
module tb_vscale_mem_arbiter;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vscale_mem_arbiter_if bus();
  vscale_mem_arbiter #(.STREAK_MAX(4)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_cmp = 0;
  int n_err = 0;

  // Memory model: answers one cycle after an accepted request.
  bit          auto_resp = 1'b1;
  bit          err_flag  = 1'b0;
  bit          ovr_en    = 1'b0;
  logic [31:0] ovr_data  = 32'h0;
  logic        hs_seen   = 1'b0;
  logic [31:0] hs_addr   = 32'h0;
  logic        auto_valid = 1'b0;
  logic [31:0] auto_data  = 32'h0;
  logic        auto_err   = 1'b0;
  logic        man_valid  = 1'b0;
  logic [31:0] man_data   = 32'h0;

  always @(negedge clk) begin
    hs_seen = bus.mem_req_valid && bus.mem_req_ready;
    hs_addr = bus.mem_addr;
  end

  always @(posedge clk) begin
    #1;
    auto_valid = hs_seen;
    auto_data  = hs_seen ? (ovr_en ? ovr_data : (hs_addr ^ 32'hA5A5_0000)) : 32'h0;
    auto_err   = hs_seen && err_flag;
  end

  assign bus.mem_resp_valid = auto_resp ? auto_valid : man_valid;
  assign bus.mem_rdata      = auto_resp ? auto_data  : man_data;
  assign bus.mem_resp_err   = auto_resp ? auto_err   : 1'b0;

  bit is_i [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    reset              = 1'b1;
    bus.imem_en        = 1'b1;
    bus.imem_addr      = 32'h0000_0100;
    bus.dmem_en        = 1'b0;
    bus.dmem_wen       = 1'b0;
    bus.dmem_size      = 3'd2;
    bus.dmem_addr      = 32'h0;
    bus.dmem_wdata     = 32'h0;
    bus.mem_req_ready  = 1'b1;

    // Reset held three cycles with a fetch pending.
    for (int i = 0; i < 3; i++) begin
      cyc(); #1;
      chk("rst_req_valid", bus.mem_req_valid, 1'b0);
      chk("rst_imem_wait", bus.imem_wait, 1'b1);
      chk("rst_imem_rdata", bus.imem_rdata, 32'h0);
    end
    reset = 1'b0;
    #1;
    chk("t1_req_valid", bus.mem_req_valid, 1'b1);
    chk("t1_req_addr", bus.mem_addr, 32'h0000_0100);
    chk("t1_imem_wait_issue", bus.imem_wait, 1'b1);
    cyc(); #1;
    chk("t1_imem_wait_resp", bus.imem_wait, 1'b0);
    chk("t1_imem_rdata", bus.imem_rdata, 32'hA5A5_0100);
    chk("t1_imem_badmem", bus.imem_badmem_e, 1'b0);
    cyc();
    bus.imem_en = 1'b0;
    #1;
    chk("t1_idle_req_valid", bus.mem_req_valid, 1'b0);
    chk("t1_idle_imem_wait", bus.imem_wait, 1'b0);

    // Streak limit: both requesting continuously.
    cyc();
    bus.imem_en   = 1'b1;
    bus.imem_addr = 32'h0000_0200;
    bus.dmem_en   = 1'b1;
    bus.dmem_wen  = 1'b0;
    bus.dmem_size = 3'd2;
    bus.dmem_addr = 32'h0000_0400;
    for (int g = 0; g < 10; g++) begin
      #1;
      chk("t2_grant_valid", bus.mem_req_valid, 1'b1);
      chk("t2_grant_addr", bus.mem_addr, is_i[g] ? 32'h0000_0200 : 32'h0000_0400);
      cyc(); #1;
      chk("t2_imem_wait", bus.imem_wait, is_i[g] ? 1'b0 : 1'b1);
      chk("t2_dmem_wait", bus.dmem_wait, is_i[g] ? 1'b1 : 1'b0);
      cyc();
    end
    bus.imem_en = 1'b0;
    bus.dmem_en = 1'b0;
    #1;
    chk("t2_idle_req_valid", bus.mem_req_valid, 1'b0);

    // Misaligned data accesses complete locally with an error.
    cyc();
    bus.dmem_en   = 1'b1;
    bus.dmem_size = 3'd2;
    bus.dmem_addr = 32'h0000_1002;
    #1;
    chk("t3_w_wait", bus.dmem_wait, 1'b0);
    chk("t3_w_badmem", bus.dmem_badmem_e, 1'b1);
    chk("t3_w_req_valid", bus.mem_req_valid, 1'b0);
    chk("t3_w_rdata", bus.dmem_rdata, 32'h0);
    cyc();
    bus.dmem_size = 3'd1;
    bus.dmem_addr = 32'h0000_1001;
    #1;
    chk("t3_h_wait", bus.dmem_wait, 1'b0);
    chk("t3_h_badmem", bus.dmem_badmem_e, 1'b1);
    chk("t3_h_req_valid", bus.mem_req_valid, 1'b0);
    cyc();
    bus.dmem_size = 3'd3;
    bus.dmem_addr = 32'h0000_2000;
    #1;
    chk("t3_ill_badmem", bus.dmem_badmem_e, 1'b1);
    chk("t3_ill_req_valid", bus.mem_req_valid, 1'b0);
    cyc();
    bus.dmem_size = 3'd0;
    bus.dmem_addr = 32'h0000_1003;
    #1;
    chk("t3_b_req_valid", bus.mem_req_valid, 1'b1);
    chk("t3_b_addr", bus.mem_addr, 32'h0000_1003);
    chk("t3_b_size", bus.mem_size, 3'd0);
    chk("t3_b_wait", bus.dmem_wait, 1'b1);
    chk("t3_b_badmem", bus.dmem_badmem_e, 1'b0);
    cyc(); #1;
    chk("t3_b_resp_wait", bus.dmem_wait, 1'b0);
    chk("t3_b_resp_rdata", bus.dmem_rdata, 32'hA5A5_1003);

    // Back-pressure: dmem store waits for ready, imem joins meanwhile.
    cyc();
    bus.mem_req_ready = 1'b0;
    bus.dmem_size     = 3'd2;
    bus.dmem_addr     = 32'h0000_3000;
    bus.dmem_wen      = 1'b1;
    bus.dmem_wdata    = 32'h1234_5678;
    #1;
    chk("t4_req_valid", bus.mem_req_valid, 1'b1);
    chk("t4_addr", bus.mem_addr, 32'h0000_3000);
    chk("t4_wen", bus.mem_wen, 1'b1);
    chk("t4_wdata", bus.mem_wdata, 32'h1234_5678);
    for (int i = 1; i < 5; i++) begin
      cyc(); #1;
      chk("t4_stall_addr", bus.mem_addr, 32'h0000_3000);
      chk("t4_stall_dwait", bus.dmem_wait, 1'b1);
    end
    cyc();
    bus.imem_en   = 1'b1;
    bus.imem_addr = 32'h0000_0500;
    #1;
    chk("t4_imem_join_addr", bus.mem_addr, 32'h0000_3000);
    chk("t4_imem_join_iwait", bus.imem_wait, 1'b1);
    cyc();
    bus.mem_req_ready = 1'b1;
    #1;
    chk("t4_ready_addr", bus.mem_addr, 32'h0000_3000);
    chk("t4_ready_iwait", bus.imem_wait, 1'b1);
    cyc(); #1;
    chk("t4_resp_dwait", bus.dmem_wait, 1'b0);
    chk("t4_resp_iwait", bus.imem_wait, 1'b1);
    err_flag = 1'b1;
    ovr_en   = 1'b1;
    ovr_data = 32'hDEAD_BEEF;

    // Fetch answered with an error.
    cyc();
    bus.dmem_en  = 1'b0;
    bus.dmem_wen = 1'b0;
    #1;
    chk("t5_addr", bus.mem_addr, 32'h0000_0500);
    chk("t5_size", bus.mem_size, 3'b010);
    chk("t5_wen", bus.mem_wen, 1'b0);
    chk("t5_wdata", bus.mem_wdata, 32'h0);
    cyc(); #1;
    chk("t5_resp_iwait", bus.imem_wait, 1'b0);
    chk("t5_resp_badmem", bus.imem_badmem_e, 1'b1);
    chk("t5_resp_rdata", bus.imem_rdata, 32'hDEAD_BEEF);
    bus.mem_req_ready = 1'b0;
    err_flag = 1'b0;
    ovr_en   = 1'b0;
    cyc(); #1;
    chk("t5_after_badmem", bus.imem_badmem_e, 1'b0);
    chk("t5_after_rdata", bus.imem_rdata, 32'h0);
    chk("t5_after_req_valid", bus.mem_req_valid, 1'b1);
    chk("t5_after_iwait", bus.imem_wait, 1'b1);
    bus.imem_en       = 1'b0;
    bus.mem_req_ready = 1'b1;

    // Reset while a data load is outstanding.
    auto_resp = 1'b0;
    cyc();
    bus.dmem_en   = 1'b1;
    bus.dmem_size = 3'd2;
    bus.dmem_addr = 32'h0000_0600;
    #1;
    chk("t6_issue_valid", bus.mem_req_valid, 1'b1);
    cyc(); #1;
    chk("t6_busy_valid", bus.mem_req_valid, 1'b0);
    chk("t6_busy_dwait", bus.dmem_wait, 1'b1);
    cyc();
    reset = 1'b1;
    #1;
    chk("t6_rst_dwait", bus.dmem_wait, 1'b1);
    chk("t6_rst_valid", bus.mem_req_valid, 1'b0);
    cyc();
    reset     = 1'b0;
    man_valid = 1'b1;
    man_data  = 32'h7777_7777;
    #1;
    chk("t6_stale_dwait", bus.dmem_wait, 1'b1);
    chk("t6_stale_badmem", bus.dmem_badmem_e, 1'b0);
    chk("t6_stale_rdata", bus.dmem_rdata, 32'h0);
    chk("t6_reissue_valid", bus.mem_req_valid, 1'b1);
    chk("t6_reissue_addr", bus.mem_addr, 32'h0000_0600);
    cyc();
    man_data = 32'h0BAD_F00D;
    #1;
    chk("t6_resp_dwait", bus.dmem_wait, 1'b0);
    chk("t6_resp_rdata", bus.dmem_rdata, 32'h0BAD_F00D);
    cyc();
    man_valid   = 1'b0;
    bus.dmem_en = 1'b0;
    #1;
    chk("t6_end_dwait", bus.dmem_wait, 1'b0);
    chk("t6_end_valid", bus.mem_req_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
